// File: rtl/en_gen_once_if.sv
// Request/status bundle of the one-shot enable-window generator.
// master = requester side, slave = en_gen_once.
interface en_gen_once_if #(
  parameter int unsigned N = 8
) ();
  logic         start;
  logic [N-1:0] len;
  logic         abort;
  logic         en;
  logic         busy;
  logic         done;
  logic [N-1:0] remain;

  modport master (
    output start, len, abort,
    input  en, busy, done, remain
  );

  modport slave (
    input  start, len, abort,
    output en, busy, done, remain
  );
endinterface

// File: rtl/en_gen_once.sv
// One-shot enable-window generator: on an accepted start, en is held high for
// exactly len cycles, followed by a single-cycle done pulse.
module en_gen_once #(
  parameter int unsigned N = 8
) (
  input  logic       clk,
  input  logic       rst,
  en_gen_once_if.slave bus
);

  localparam logic [N-1:0] REM_ZERO = '0;
  localparam logic [N-1:0] REM_ONE  = N'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic         en_q, en_nxt;
  logic         busy_q, busy_nxt;
  logic         done_q, done_nxt;
  logic [N-1:0] remain_q, remain_nxt;

  // State and registered outputs; reset wins over every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      remain_q <= REM_ZERO;
    end else begin
      state    <= state_nxt;
      en_q     <= en_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      remain_q <= remain_nxt;
    end
  end

  // Next state and the output values that go with it.
  always_comb begin
    state_nxt  = IDLE;
    en_nxt     = 1'b0;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    remain_nxt = REM_ZERO;

    unique case (state)
      IDLE: begin
        // abort outranks start; len is sampled only here
        if (bus.start && !bus.abort) begin
          busy_nxt = 1'b1;
          if (bus.len != REM_ZERO) begin
            state_nxt  = RUN;
            en_nxt     = 1'b1;
            remain_nxt = bus.len;
          end else begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end
        end
      end

      RUN: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (remain_q == REM_ONE) begin
          state_nxt = DONE;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b1;
        end else begin
          state_nxt  = RUN;
          en_nxt     = 1'b1;
          busy_nxt   = 1'b1;
          remain_nxt = remain_q - REM_ONE;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.en     = en_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.remain = remain_q;

endmodule

// File: tb/tb_en_gen_once.sv
// Self-checking bench for en_gen_once: directed vector table, hand-written
// corner sequences and randomized traffic against a scheduled-output model.
module tb_en_gen_once;

  localparam int unsigned N = 8;

  logic clk;
  logic rst;

  en_gen_once_if #(.N(N)) bus ();

  en_gen_once #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         start;
    logic         abort;
    logic [N-1:0] len;
    logic         en;
    logic         busy;
    logic         done;
    logic [N-1:0] remain;
  } vec_t;

  typedef struct {
    logic         en;
    logic         busy;
    logic         done;
    logic [N-1:0] remain;
  } out_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  out_t sched[$];
  out_t expo;
  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: an accepted request schedules its whole future output sequence;
  // abort during the en part or reset drops what is left.
  task automatic model_edge(input logic r, input logic s, input logic a,
                            input logic [N-1:0] l);
    out_t o;
    if (r) begin
      sched.delete();
    end else if (sched.size() == 0) begin
      if (s && !a) begin
        for (int i = 0; i < int'(l); i++) begin
          o.en = 1'b1; o.busy = 1'b1; o.done = 1'b0; o.remain = N'(int'(l) - i);
          sched.push_back(o);
        end
        o.en = 1'b0; o.busy = 1'b1; o.done = 1'b1; o.remain = '0;
        sched.push_back(o);
      end
    end else if (sched[0].en && a) begin
      sched.delete();
    end else begin
      void'(sched.pop_front());
    end
    if (sched.size() != 0) expo = sched[0];
    else begin
      expo.en = 1'b0; expo.busy = 1'b0; expo.done = 1'b0; expo.remain = '0;
    end
  endtask

  // One clock: drive on negedge, sample 1 time unit after posedge.
  task automatic step(input logic r, input logic s, input logic a,
                      input logic [N-1:0] l, input bit cmp_model);
    @(negedge clk);
    rst = r; bus.start = s; bus.abort = a; bus.len = l;
    @(posedge clk);
    model_edge(r, s, a, l);
    #1;
    if (cmp_model) begin
      check("model_en",     int'(bus.en),     int'(expo.en));
      check("model_busy",   int'(bus.busy),   int'(expo.busy));
      check("model_done",   int'(bus.done),   int'(expo.done));
      check("model_remain", int'(bus.remain), int'(expo.remain));
    end
  endtask

  function automatic vec_t v(input logic r, input logic s, input logic a,
                             input int l, input logic e, input logic b,
                             input logic d, input int rem);
    vec_t x;
    x.rst = r; x.start = s; x.abort = a; x.len = N'(l);
    x.en = e; x.busy = b; x.done = d; x.remain = N'(rem);
    return x;
  endfunction

  int en_cnt;
  int done_cnt;
  int busy_cnt;

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.abort = 1'b0; bus.len = '0;

    //          rst s a len   en b d rem
    tbl.push_back(v(1, 0, 0, 0,  0, 0, 0, 0));  // reset state
    tbl.push_back(v(1, 1, 0, 5,  0, 0, 0, 0));  // rst beats start
    tbl.push_back(v(0, 1, 0, 5,  1, 1, 0, 5));  // accepted in first cycle after rst
    tbl.push_back(v(0, 0, 0, 9,  1, 1, 0, 4));  // len change ignored
    tbl.push_back(v(0, 1, 0, 9,  1, 1, 0, 3));  // start ignored in RUN
    tbl.push_back(v(0, 0, 0, 0,  1, 1, 0, 2));
    tbl.push_back(v(0, 0, 0, 0,  1, 1, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,  0, 1, 1, 0));  // done pulse
    tbl.push_back(v(0, 1, 0, 4,  0, 0, 0, 0));  // start ignored in DONE
    tbl.push_back(v(0, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0,  0, 1, 1, 0));  // len 0 -> straight to DONE
    tbl.push_back(v(0, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 3,  0, 0, 0, 0));  // abort beats start
    tbl.push_back(v(0, 0, 1, 3,  0, 0, 0, 0));  // abort ignored in IDLE
    tbl.push_back(v(0, 1, 0, 1,  1, 1, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,  0, 1, 1, 0));
    tbl.push_back(v(0, 0, 1, 0,  0, 0, 0, 0));  // abort ignored in DONE
    tbl.push_back(v(0, 1, 0, 1,  1, 1, 0, 1));
    tbl.push_back(v(0, 0, 1, 0,  0, 0, 0, 0));  // abort on final cycle, no done
    tbl.push_back(v(0, 0, 0, 0,  0, 0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].start, tbl[i].abort, tbl[i].len, 1'b0);
      check($sformatf("vec%0d_en", i),     int'(bus.en),     int'(tbl[i].en));
      check($sformatf("vec%0d_busy", i),   int'(bus.busy),   int'(tbl[i].busy));
      check($sformatf("vec%0d_done", i),   int'(bus.done),   int'(tbl[i].done));
      check($sformatf("vec%0d_remain", i), int'(bus.remain), int'(tbl[i].remain));
    end

    // len=5: 5 en cycles, 6 busy cycles, one done
    en_cnt = 0; busy_cnt = 0; done_cnt = 0;
    step(0, 1, 0, 5, 1'b1);
    for (int i = 0; i < 8; i++) begin
      en_cnt += int'(bus.en); busy_cnt += int'(bus.busy); done_cnt += int'(bus.done);
      step(0, 0, 0, 0, 1'b1);
    end
    check("len5_en_cycles", en_cnt, 5);
    check("len5_busy_cycles", busy_cnt, 6);
    check("len5_done_cycles", done_cnt, 1);

    // len=10, abort in the 4th en cycle
    en_cnt = 0; done_cnt = 0;
    step(0, 1, 0, 10, 1'b1);
    en_cnt += int'(bus.en);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1'b1);
      en_cnt += int'(bus.en);
    end
    step(0, 0, 1, 0, 1'b1);
    check("abort_en_low", int'(bus.en), 0);
    check("abort_remain", int'(bus.remain), 0);
    for (int i = 0; i < 4; i++) begin
      done_cnt += int'(bus.done);
      step(0, 0, 0, 0, 1'b1);
    end
    check("abort_en_cycles", en_cnt, 4);
    check("abort_no_done", done_cnt, 0);

    // start held high, len changed mid-window: back-to-back windows of 3
    en_cnt = 0;
    step(0, 1, 0, 3, 1'b1);  en_cnt += int'(bus.en);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 7, 1'b1); en_cnt += int'(bus.en);
    end
    check("held_gap_en_low", int'(bus.en), 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 3, 1'b1); en_cnt += int'(bus.en);
    end
    check("held_en_cycles", en_cnt, 6);
    step(0, 0, 0, 0, 1'b1);
    step(0, 0, 0, 0, 1'b1);

    // len=255, reset at remain=100, then a fresh len=2 window
    step(0, 1, 0, 255, 1'b1);
    check("max_remain_start", int'(bus.remain), 255);
    for (int i = 0; i < 155; i++) step(0, 0, 0, 0, 1'b1);
    check("max_remain_100", int'(bus.remain), 100);
    step(1, 1, 1, 0, 1'b1);
    check("midrun_rst_busy", int'(bus.busy), 0);
    check("midrun_rst_done", int'(bus.done), 0);
    en_cnt = 0;
    step(0, 1, 0, 2, 1'b1); en_cnt += int'(bus.en);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1'b1); en_cnt += int'(bus.en);
    end
    check("after_rst_en_cycles", en_cnt, 2);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic         r, s, a;
      logic [N-1:0] l;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 2) == 0);
      a = ($urandom_range(0, 11) == 0);
      l = ($urandom_range(0, 9) == 0) ? N'($urandom_range(0, 255))
                                      : N'($urandom_range(0, 6));
      step(r, s, a, l, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
